// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: elastic inter-stage buffer with a valid/ready handshake.
// A WIDTH-bit, DEPTH-entry circular buffer that replaces enable-gated
// pipeline latches. Back-pressure travels upstream through in_ready.
// Optional feature macro: PIPE_STAGE_STATS_EN adds a saturating stall_cycles counter.
//
// Handshake: a transfer happens on a rising CLK edge when valid and ready are
// both high in the preceding cycle. push = in_valid & in_ready and
// pop = out_valid & out_ready. A producer holding valid high must keep its data
// stable until that handshake. in_ready depends only on occupancy and RST, so
// there is no combinational path from out_ready. out_valid is registered state,
// so there is no path from in_valid.
module pipe_stage_buf #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count
`ifdef PIPE_STAGE_STATS_EN
    ,
    output logic [31:0]      stall_cycles
`endif
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;

    // Handshake events and the flow-control / masked output drive.
    always_comb begin
        in_ready  = (count_q < DEPTH_C) & ~RST;
        out_valid = (count_q != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        out_data  = out_valid ? mem_q[rp_q] : '0;
        count     = count_q;
    end

    // Next pointers and occupancy; flush discards any push/pop of this cycle.
    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    always_comb begin
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (flush) begin
            wp_d    = '0;
            rp_d    = '0;
            count_d = '0;
        end else begin
            if (push) begin
                wp_d = (wp_q == LAST_C) ? '0 : wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = (rp_q == LAST_C) ? '0 : rp_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers; reset takes priority over flush.
    always_ff @(posedge CLK) begin
        if (RST) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    // Entry storage; flushed entries keep stale data since out_data is masked.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (!flush && push) begin
            mem_q[wp_q] <= in_data;
        end
    end

`ifdef PIPE_STAGE_STATS_EN
    logic [31:0] stall_q;

    // Saturating count of cycles where the head is held by the consumer.
    // Cleared only by RST so that squashes do not hide stall history.
    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
        end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: doc/pipe_stage_buf.md
# pipe_stage_buf

Parametrised elastic pipeline-stage register that replaces the fixed, enable-gated inter-stage latches (EX/MEM, MEM/WB) with a WIDTH-bit, DEPTH-entry buffer using a valid/ready handshake, synchronous flush and occupancy reporting. It sits between any two pipeline stages of the datapath. Upstream stalls no longer have to be broadcast as a global write enable, because back-pressure propagates through `in_ready`.

## Interface
- WIDTH, 32, bits per payload; the packed stage bundle, e.g. MemToReg, wsel, WEN, port output and dmemload.
- DEPTH, 2, number of entries; legal range 1..16; need not be a power of two.
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous clear of all entries, for branch or exception squash.
- in_valid  in  1  upstream offers `in_data`.
- in_ready  out  1  buffer accepts this cycle.
- in_data  in  WIDTH  payload.
- out_valid  out  1  head entry present.
- out_ready  in  1  downstream consumes head.
- out_data  out  WIDTH  head payload.
- count  out  $clog2(DEPTH+1)  current occupancy.
- stall_cycles  out  32  only with `PIPE_STAGE_STATS_EN`; see Configuration.

## Operation
- Circular buffer:
  - Write pointer `wp`, read pointer `rp`, occupancy `count`.
  - Both pointers wrap from DEPTH-1 to 0 by explicit compare, not by power-of-two masking.
- Handshake events:
  - push = `in_valid & in_ready`.
  - pop = `out_valid & out_ready`.
- Flow-control outputs:
  - `in_ready` = (count < DEPTH) & !RST.
  - `in_ready` has no combinational dependence on `out_ready`.
- Output drive:
  - `out_valid` = (count != 0).
  - `out_data` = entry[rp] when `out_valid`, else all zeros (masked).
- Per-cycle update, in priority order:
  - RST: wp=rp=count=0; all entries cleared to 0.
  - flush: wp=rp=count=0. Any push and pop this cycle are discarded. Entry contents are not required to clear, since the output is masked.
  - Otherwise:
    - push writes entry[wp] and advances wp.
    - pop advances rp.
    - count += push − pop.
- Simultaneous push and pop at 0 < count < DEPTH: count is unchanged and both pointers advance.
- Full (count = DEPTH): `in_ready`=0, so no push occurs. A pop this cycle does not enable a same-cycle push; `in_ready` rises the next cycle.
- Empty: no pop is possible. A push makes `out_valid`=1 the next cycle; there is no fall-through.
- Data stability: while `out_valid & !out_ready`, `out_data` holds constant.
- DEPTH=1:
  - Behaves as a plain stage register with stall.
  - Throughput is at most one transfer every 2 cycles under continuous `out_ready`.
  - DEPTH≥2 sustains 1 transfer per cycle.

## Timing
- Latency: `in_data` accepted at edge N appears on `out_data` with `out_valid`=1 after edge N, i.e. in cycle N+1.
- Reset values:
  - `in_ready`=0 while RST is high, 1 in the first cycle after RST deasserts.
  - `out_valid`=0, `out_data`=0, `count`=0.
  - `stall_cycles`=0.
- Reset mid-operation: the stored entries are lost. No transfer completes on the reset edge, even if the handshakes were high.
- Flush takes effect at the next edge. In the following cycle `out_valid`=0, `count`=0 and `in_ready`=1.
- No combinational paths:
  - `out_ready` to `in_ready`.
  - `in_valid` to `out_valid`.

## Configuration
- `PIPE_STAGE_STATS_EN` defined:
  - Adds a 32-bit `stall_cycles` output port.
  - Increments on every cycle with `out_valid & !out_ready`.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by RST. Not cleared by flush.
- `PIPE_STAGE_STATS_EN` undefined: the port and the counter are absent, and the remaining behaviour is identical.

## Test plan
- Reset, then streaming:
  - Stimulus: RST for 2 cycles, then stream 0x11, 0x22, 0x33 with `out_ready`=1 (DEPTH=2).
  - Required response: each word appears one cycle after acceptance, in order; `count` stays ≤1; `in_ready` stays 1.
- Fill and back-pressure:
  - Stimulus: `out_ready`=0, push 0xA, 0xB, 0xC (DEPTH=2).
  - Required response: 0xA and 0xB accepted; `in_ready`=0 with `count`=2; 0xC held upstream. Raise `out_ready`: 0xA, 0xB, 0xC emerge in order; `in_ready` returns the cycle after the first pop.
- Wrap-around:
  - Stimulus: DEPTH=3, 10 words 0..9 with random `in_valid`/`out_ready` patterns.
  - Required response: output sequence exactly 0..9; pointers cross index 2→0 at least 3 times.
- Flush with push:
  - Stimulus: `count`=2; assert `flush` and push 0x55 in the same cycle.
  - Required response: next cycle `count`=0, `out_valid`=0, `out_data`=0; 0x55 is not stored.
- Reset mid-stream:
  - Stimulus: assert RST while `count`=1 and a push/pop handshake is active.
  - Required response: next cycle all outputs at reset values; the first post-reset push reappears alone.
- Stats (with `PIPE_STAGE_STATS_EN`):
  - Stimulus: hold `out_valid`=1, `out_ready`=0 for 7 cycles, then flush.
  - Required response: `stall_cycles`=7 and still 7 after the flush.
